display_framebuffer: RTL and testbench
======================================

Name: display_framebuffer

Overview:
- Double-buffered pixel store sitting directly upstream of display_driver.
- Serves the driver's {row, column} read address with registered pixel data.
- Accepts pixel writes from the content source into the back buffer.
- Swaps front and back buffers only on the driver's frame_complete, so no frame is displayed torn. A back-buffer clear engine is included.

Parameters:
- segments, 1, panel segments driven in parallel; pixel word is segments*3*bitwidth bits
- rows, 8, rows per segment (power of 2)
- columns, 32, columns per row (power of 2)
- bitwidth, 10, bits per colour channel

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- row  in  log2(rows)  driver read row
- column  in  log2(columns)  driver read column
- pixel  out  segments*3*bitwidth  front-buffer word at {row, column}, registered
- frame_complete  in  1  driver safe-flip strobe
- wr_en  in  1  write strobe
- wr_addr  in  log2(rows)+log2(columns)  write address {row, column}
- wr_data  in  segments*3*bitwidth  write word
- wr_ready  out  1  high when writes are accepted
- clear  in  1  pulse: start zero-fill of back buffer
- swap_req  in  1  pulse: request buffer swap at next frame_complete
- swap_pending  out  1  swap requested, not yet performed
- swap_done  out  1  one-cycle pulse when swap takes effect
- front  out  1  index of the buffer currently displayed

Behaviour:
- Reset (rst low, async): front=0, pixel=0, swap_pending=0, swap_done=0, wr_ready=1, state=IDLE. RAM contents are not reset and are undefined until written or cleared.
- Storage: 2 banks of rows*columns words. The back bank is always !front.
- Read path:
  - pixel <= bank[front][{row, column}] every cycle; latency is exactly 1 clk.
  - No read enable; reads never stall.
- Write path:
  - In IDLE with wr_en=1: bank[!front][wr_addr] <= wr_data.
  - wr_ready=1 only in IDLE. Writes with wr_ready=0 are dropped silently.
  - The front bank is never written.
- Clear engine, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear=1. Counter=0, wr_ready drops on the next cycle.
  - CLEAR: write 0 to bank[!front][counter], then counter++. After address rows*columns-1 -> IDLE.
  - Total duration is exactly rows*columns cycles. clear asserted while in CLEAR is ignored (no restart).
  - wr_en in the same cycle as clear (from IDLE): the write is performed, and the clear then overwrites it.
- Swap:
  - swap_req=1 sets swap_pending. Repeat requests while pending are no-ops.
  - Swap fires when swap_pending=1, frame_complete=1 and state=IDLE. On the next edge: front toggles, swap_pending clears, and swap_done pulses for 1 cycle.
  - frame_complete while in CLEAR: the swap is deferred to the first frame_complete after CLEAR ends. A clear never straddles a swap.
  - frame_complete with swap_pending=0 has no effect.
  - swap_req in the same cycle as a firing frame_complete is treated as arriving after the swap. It sets swap_pending again.
  - A write in the same cycle as the swap edge lands in the pre-swap back bank, which becomes the new front.
  - The read in the swap cycle uses the old front. The new front is visible from the following address sample.
- Reset mid-clear or mid-pending: state returns to IDLE, pending is lost, and RAM is left partially cleared.
- The counter is log2(rows)+log2(columns) bits and wraps naturally. Exit from CLEAR is decoded on the all-ones value.

Test Plan:
- Reset, clear, wait 256 cycles, write 30'h3ff00000 to addr 0, swap_req, pulse frame_complete. Expect swap_done 1 cycle later and front=1. Expect row=0, column=0 to give pixel=30'h3ff00000 one clk later, and every other address to read 0.
- Write addr 5 = 30'h155 with swap_pending=0, pulse frame_complete. Expect front unchanged, no swap_done, and a read of addr 5 returns the old front value.
- clear, then assert wr_en during the 256-cycle clear. Expect wr_ready=0 for exactly 256 cycles and writes dropped; back bank reads all 0 after swap.
- swap_req during clear with frame_complete at clear cycle 100. Expect no swap; swap fires at the first frame_complete after wr_ready returns to 1.
- Sweep addresses 0..255 with back-to-back reads. Expect pixel to track address with exactly 1-cycle latency and no bubbles.
- Drop rst mid-clear at cycle 50. Expect immediate front=0, pixel=0, swap_pending=0, wr_ready=1. A subsequent write is accepted on the first clk after release.

Source files
------------

// File: rtl/display_framebuffer.sv
// Double-buffered pixel store: the driver reads the front bank, the content source
// writes the back bank, and the banks flip only on the driver's frame_complete.
module display_framebuffer #(
  parameter int segments = 1,
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [$clog2(rows)-1:0]             row,
  input  logic [$clog2(columns)-1:0]          column,
  output logic [segments*3*bitwidth-1:0]      pixel,
  input  logic                                frame_complete,
  input  logic                                wr_en,
  input  logic [$clog2(rows)+$clog2(columns)-1:0] wr_addr,
  input  logic [segments*3*bitwidth-1:0]      wr_data,
  output logic                                wr_ready,
  input  logic                                clear,
  input  logic                                swap_req,
  output logic                                swap_pending,
  output logic                                swap_done,
  output logic                                front
);

  // state | meaning
  // IDLE  | accepting writes, swap may fire on frame_complete
  // CLEAR | zero-filling the back bank, one word per cycle

  localparam int RW    = $clog2(rows);
  localparam int CW    = $clog2(columns);
  localparam int AW    = RW + CW;
  localparam int DW    = segments * 3 * bitwidth;
  localparam int DEPTH = rows * columns;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          we;
  logic [AW:0]   waddr;
  logic [DW-1:0] wdata;
  logic          fire;

  // Both banks share one array; the MSB of the index selects the bank.
  logic [DW-1:0] mem [0:2*DEPTH-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we        = 1'b0;
    waddr     = {~front, wr_addr};
    wdata     = wr_data;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        we   = wr_en;
        fire = swap_pending & frame_complete;
        if (clear) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        we      = 1'b1;
        waddr   = {~front, cnt};
        wdata   = '0;
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      front        <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      pixel        <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      swap_done <= fire;
      // The read samples the pre-swap front; the flip shows from the next address.
      pixel     <= mem[{front, row, column}];
      if (fire) begin
        front        <= ~front;
        swap_pending <= swap_req;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_display_framebuffer.sv
// Randomised and directed checks of display_framebuffer against a bank-array model.
module tb_display_framebuffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  row = '0;
  logic [4:0]  column = '0;
  logic [29:0] pixel;
  logic        frame_complete = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [29:0] wr_data = '0;
  logic        wr_ready;
  logic        clear = 1'b0;
  logic        swap_req = 1'b0;
  logic        swap_pending;
  logic        swap_done;
  logic        front;

  display_framebuffer dut (
    .clk(clk), .rst(rst), .row(row), .column(column), .pixel(pixel),
    .frame_complete(frame_complete), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .clear(clear), .swap_req(swap_req),
    .swap_pending(swap_pending), .swap_done(swap_done), .front(front)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: two banks with known-flags, a count of clear cycles left, swap flags.
  logic [29:0] m_mem [0:1][0:255];
  bit          m_kn  [0:1][0:255];
  bit          m_front = 1'b0;
  bit          m_pend  = 1'b0;
  bit          m_done  = 1'b0;
  int          m_clr_left = 0;
  logic [29:0] m_pix = '0;
  bit          m_pix_kn = 1'b1;
  int          m_a, m_fr, m_bk, m_ca;
  bit          m_idle, m_fire;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_front = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_clr_left = 0;
        m_pix = '0; m_pix_kn = 1'b1;
      end else begin
        m_a  = {row, column};
        m_fr = m_front ? 1 : 0;
        m_bk = 1 - m_fr;
        m_pix    = m_mem[m_fr][m_a];
        m_pix_kn = m_kn[m_fr][m_a];
        m_idle = (m_clr_left == 0);
        m_fire = m_idle && m_pend && frame_complete;
        if (m_idle && wr_en) begin
          m_mem[m_bk][wr_addr] = wr_data;
          m_kn[m_bk][wr_addr]  = 1'b1;
        end
        if (!m_idle) begin
          m_ca = 256 - m_clr_left;
          m_mem[m_bk][m_ca] = '0;
          m_kn[m_bk][m_ca]  = 1'b1;
          m_clr_left--;
        end
        if (m_idle && clear) m_clr_left = 256;
        m_done = m_fire;
        m_pend = m_fire ? swap_req : (m_pend || swap_req);
        if (m_fire) m_front = !m_front;
      end
      #1;
      if (chk_en) begin
        chk("front", {31'd0, front}, {31'd0, m_front});
        chk("swap_pending", {31'd0, swap_pending}, {31'd0, m_pend});
        chk("swap_done", {31'd0, swap_done}, {31'd0, m_done});
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, (m_clr_left == 0)});
        if (m_pix_kn) chk("pixel", {2'b0, pixel}, {2'b0, m_pix});
      end
    end
  end

  task automatic set_addr(input int a);
    logic [7:0] v;
    v = a[7:0];
    row    = v[7:5];
    column = v[4:0];
  endtask

  // Pulse clear, fire random writes while wr_ready is low, return the low-time.
  task automatic clear_measure(output int n);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n = 0;
    while (!wr_ready && n < 600) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = 8'($urandom);
      wr_data = 30'($urandom);
      n++;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!wr_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'd0, wr_ready}, 32'd1);
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    frame_complete = 1'b1;
    @(negedge clk);
    frame_complete = 1'b0;
  endtask

  task automatic sweep_nonzero(input int skip, output int nz);
    nz = 0;
    for (int i = 0; i < 256; i++) begin
      set_addr(i);
      @(negedge clk);
      if (i != skip && pixel != '0) nz++;
    end
  endtask

  int len, nz;

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_front", {31'd0, front}, 32'd0);
    chk("rst_pixel", {2'b0, pixel}, 32'd0);
    chk("rst_pending", {31'd0, swap_pending}, 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_done", {31'd0, swap_done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Clear back bank 1, write addr 0, swap it to the front.
    clear_measure(len);
    chk("t1_clear_len", len, 256);
    wr_en = 1'b1; wr_addr = 8'd0; wr_data = 30'h3ff00000;
    @(negedge clk);
    wr_en = 1'b0;
    do_swap();
    chk("t1_done", {31'd0, swap_done}, 32'd1);
    chk("t1_front", {31'd0, front}, 32'd1);
    set_addr(0);
    @(negedge clk);
    chk("t1_pix0", {2'b0, pixel}, 32'h3ff00000);
    chk("t1_done_pulse", {31'd0, swap_done}, 32'd0);
    sweep_nonzero(0, nz);
    chk("t1_others_zero", nz, 0);

    // frame_complete without a pending swap.
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 30'h155;
    @(negedge clk);
    wr_en = 1'b0; frame_complete = 1'b1;
    @(negedge clk);
    frame_complete = 1'b0;
    chk("t2_no_done", {31'd0, swap_done}, 32'd0);
    chk("t2_front", {31'd0, front}, 32'd1);
    set_addr(5);
    @(negedge clk);
    chk("t2_old_front", {2'b0, pixel}, 32'd0);

    // Writes during clear are dropped; cleared bank reads all zero.
    clear_measure(len);
    chk("t3_clear_len", len, 256);
    do_swap();
    chk("t3_front", {31'd0, front}, 32'd0);
    sweep_nonzero(-1, nz);
    chk("t3_all_zero", nz, 0);

    // Swap requested during clear is deferred past it.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    repeat (97) @(negedge clk);
    frame_complete = 1'b1;
    @(negedge clk);
    frame_complete = 1'b0;
    chk("t4_deferred_front", {31'd0, front}, 32'd0);
    chk("t4_still_pending", {31'd0, swap_pending}, 32'd1);
    wait_ready();
    chk("t4_no_early_swap", {31'd0, front}, 32'd0);
    frame_complete = 1'b1;
    @(negedge clk);
    frame_complete = 1'b0;
    chk("t4_done", {31'd0, swap_done}, 32'd1);
    chk("t4_front", {31'd0, front}, 32'd1);

    // Randomised traffic, model-checked every cycle.
    for (int c = 0; c < 4000; c++) begin
      wr_en          = ($urandom_range(0, 1) == 1);
      wr_addr        = 8'($urandom);
      wr_data        = 30'($urandom);
      clear          = ($urandom_range(0, 149) == 0);
      swap_req       = ($urandom_range(0, 19) == 0);
      frame_complete = ($urandom_range(0, 15) == 0);
      set_addr($urandom_range(0, 255));
      @(negedge clk);
    end
    wr_en = 1'b0; clear = 1'b0; swap_req = 1'b0; frame_complete = 1'b0;
    for (int i = 0; i < 256; i++) begin
      set_addr(i);
      @(negedge clk);
    end
    wait_ready();

    // Reset mid-clear with a swap pending.
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (49) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_front", {31'd0, front}, 32'd0);
    chk("t6_pixel", {2'b0, pixel}, 32'd0);
    chk("t6_pending", {31'd0, swap_pending}, 32'd0);
    chk("t6_ready", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 8'h33; wr_data = 30'h2aaaaaaa;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t6_ready_after", {31'd0, wr_ready}, 32'd1);
    do_swap();
    chk("t6_done", {31'd0, swap_done}, 32'd1);
    set_addr(8'h33);
    @(negedge clk);
    chk("t6_write_kept", {2'b0, pixel}, 32'h2aaaaaaa);
    for (int i = 0; i < 256; i++) begin
      set_addr(i);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
